flash_spi_seq: RTL and testbench

//  Byte-level SPI sequencer for the external QSPI flash (fsclk/fcen/fdio).

---
 rtl/flash_spi_seq_if.sv | 31 +++
 rtl/flash_spi_seq.sv | 163 ++++++++++++++++
 tb/tb_flash_spi_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/flash_spi_seq_if.sv
// rtl/flash_spi_seq_if.sv - command/response bundle between flash-writer host and flash_spi_seq
// FLASH_SEQ_QUAD_EN adds cmd_quad for quad-mode READ.
interface flash_spi_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
`ifdef FLASH_SEQ_QUAD_EN
  logic       cmd_quad;
`endif
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err;
  logic       busy;

  modport master (
`ifdef FLASH_SEQ_QUAD_EN
    output cmd_quad,
`endif
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, err, busy
  );

  modport slave (
`ifdef FLASH_SEQ_QUAD_EN
    input  cmd_quad,
`endif
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, err, busy
  );
endinterface

// File: rtl/flash_spi_seq.sv
// rtl/flash_spi_seq.sv - byte-level SPI mode-0 sequencer (START/STOP/WRITE/READ) for the QSPI flash
// FLASH_SEQ_QUAD_EN enables quad READ (nibble per SCK on fdio_i[3:0], fdio_oe released).
module flash_spi_seq #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                  HCLK,
  input  logic                  RST,
  flash_spi_seq_if.slave        host,
  output logic                  fsclk,
  output logic                  fcen,
  output logic [3:0]            fdio_o,
  output logic [3:0]            fdio_oe,
  input  logic [3:0]            fdio_i
);

  localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(CS_GAP - 1);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SH_LO, S_SH_HI, S_CS_HOLD, S_CS_GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic          tx_bit;
  logic [7:0]    rx_sh;
  logic          rd_q;
  logic          quad_q;
  logic          fcen_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic          err_q;

  logic accept, div_done, last_cell;

  assign accept    = host.cmd_valid && (state == S_IDLE);
  assign div_done  = (div_cnt == '0);
  assign last_cell = quad_q ? (bit_cnt == 3'd1) : (bit_cnt == 3'd7);

  always_ff @(posedge HCLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (host.cmd_op)
            OP_START: if (fcen_q)  state_nxt = S_CS_SETUP;
            OP_STOP:  if (!fcen_q) state_nxt = S_CS_HOLD;
            default:  if (!fcen_q) state_nxt = S_SH_LO;
          endcase
        end
      end
      S_CS_SETUP: if (div_done) state_nxt = S_IDLE;
      S_SH_LO:    if (div_done) state_nxt = S_SH_HI;
      S_SH_HI:    if (div_done) state_nxt = last_cell ? S_IDLE : S_SH_LO;
      S_CS_HOLD:  if (div_done) state_nxt = S_CS_GAP;
      S_CS_GAP:   if (div_done) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    host.cmd_ready = (state == S_IDLE);
    host.busy      = (state != S_IDLE);
    fsclk          = (state == S_SH_HI);
    fcen           = fcen_q;
    fdio_o         = {2'b11, 1'b0, tx_bit};
    fdio_oe        = quad_q ? 4'b0000 : 4'b1101;
  end

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.err       = err_q;

  always_ff @(posedge HCLK or negedge RST) begin
    if (!RST) begin
      div_cnt     <= '0;
      bit_cnt     <= 3'd0;
      tx_sh       <= 8'h00;
      tx_bit      <= 1'b0;
      rx_sh       <= 8'h00;
      rd_q        <= 1'b0;
      fcen_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;

      // Every phase change reloads the divider; the gap phase has its own length.
      if (state_nxt == S_CS_GAP && state != S_CS_GAP) div_cnt <= GAP_LD;
      else if (state_nxt != state)                     div_cnt <= DIV_LD;
      else if (!div_done)                              div_cnt <= div_cnt - CW'(1);

      if (accept) begin
        case (host.cmd_op)
          OP_START: if (fcen_q) fcen_q <= 1'b0;
          OP_STOP:  ;
          default: begin
            if (fcen_q) begin
              err_q <= 1'b1;
            end else begin
              rd_q    <= (host.cmd_op == OP_READ);
              bit_cnt <= 3'd0;
              tx_sh   <= (host.cmd_op == OP_READ) ? 8'h00 : host.cmd_data;
              tx_bit  <= (host.cmd_op == OP_READ) ? 1'b0  : host.cmd_data[7];
            end
          end
        endcase
      end

      if (state == S_CS_HOLD && div_done) fcen_q <= 1'b1;

      // Sample on the HCLK edge that raises fsclk.
      if (state == S_SH_LO && div_done && rd_q)
        rx_sh <= quad_q ? {rx_sh[3:0], fdio_i} : {rx_sh[6:0], fdio_i[1]};

      if (state == S_SH_HI && div_done) begin
        if (last_cell) begin
          bit_cnt <= 3'd0;
          tx_bit  <= 1'b0;
          if (rd_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_sh;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sh   <= {tx_sh[6:0], 1'b0};
          tx_bit  <= tx_sh[6];
        end
      end
    end
  end

`ifdef FLASH_SEQ_QUAD_EN
  always_ff @(posedge HCLK or negedge RST) begin
    if (!RST)
      quad_q <= 1'b0;
    else if (accept && host.cmd_op == OP_READ && !fcen_q)
      quad_q <= host.cmd_quad;
    else if (state == S_SH_HI && div_done && last_cell)
      quad_q <= 1'b0;
  end
`else
  assign quad_q = 1'b0;
`endif

endmodule

// File: tb/tb_flash_spi_seq.sv
// tb/tb_flash_spi_seq.sv - scoreboard bench for flash_spi_seq with a small SPI flash model
// FLASH_SEQ_QUAD_EN adds the quad read sequence.
module tb_flash_spi_seq;
  logic HCLK = 1'b0;
  logic RST  = 1'b1;
  always #5 HCLK = ~HCLK;

  flash_spi_seq_if host();
  logic       fsclk, fcen;
  logic [3:0] fdio_o, fdio_oe, fdio_i;
  logic       quad_req;

`ifdef FLASH_SEQ_QUAD_EN
  assign host.cmd_quad = quad_req;
`endif

  flash_spi_seq #(.CLK_DIV(4), .CS_GAP(4)) dut (
    .HCLK(HCLK), .RST(RST), .host(host),
    .fsclk(fsclk), .fcen(fcen), .fdio_o(fdio_o), .fdio_oe(fdio_oe), .fdio_i(fdio_i)
  );

  localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_WRITE = 2'b10, OP_READ = 2'b11;
  localparam logic [21:0] RST_V = 22'b1_0_00000000_0_0_0_1_1100_1101;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  // Flash model: JEDEC ID for 0x9F, quad fast read 0x6B with mem[a] = a ^ 0x5A.
  int         m_bits, m_bytes;
  logic [7:0] m_in, m_cmd, m_out, m_next, q_addr, qb;
  logic [3:0] q_nib;
  bit         m_pend, q_mode, q_half, sck_d;

  function automatic logic [7:0] resp(input logic [7:0] c, input int idx);
    if (c == 8'h9F && idx == 1) return 8'hBF;
    if (c == 8'h9F && idx == 2) return 8'h26;
    if (c == 8'h9F && idx == 3) return 8'h58;
    return 8'hFF;
  endfunction

  assign fdio_i = q_mode ? q_nib : {2'b11, m_out[7], 1'b1};

  initial begin
    m_out = 8'hFF; q_mode = 0; q_nib = 4'hF; sck_d = 0;
  end

  always @(fcen or fsclk) begin
    if (fcen) begin
      m_bits = 0; m_bytes = 0; m_pend = 0; m_out = 8'hFF; q_mode = 0; q_half = 0; m_cmd = 8'h00;
    end else if (fsclk && !sck_d && !q_mode) begin
      m_in = {m_in[6:0], fdio_o[0]};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (m_bytes == 0) m_cmd = m_in;
        if (m_cmd == 8'h6B && m_bytes == 3) q_addr = m_in;
        if (m_cmd == 8'h6B && m_bytes == 4) q_mode = 1;
        m_bytes++;
        m_next = resp(m_cmd, m_bytes);
        m_pend = 1;
      end
    end else if (!fsclk && sck_d) begin
      if (q_mode) begin
        qb = q_addr ^ 8'h5A;
        if (!q_half) begin q_nib = qb[7:4]; q_half = 1; end
        else begin q_nib = qb[3:0]; q_half = 0; q_addr = q_addr + 8'd1; end
      end else if (m_pend) begin
        m_out = m_next; m_pend = 0;
      end else begin
        m_out = {m_out[6:0], 1'b1};
      end
    end
    sck_d = fsclk;
  end

  int         n_sck = 0;
  logic [7:0] tx_cap = 8'h00;
  always @(posedge fsclk) begin
    n_sck++;
    tx_cap = {tx_cap[6:0], fdio_o[0]};
  end

  bit fwatch = 0, qwatch = 0;
  int fcen_hi = 0, qbad = 0;
  always @(negedge HCLK) begin
    if (fwatch && fcen) fcen_hi++;
    if (qwatch && host.busy && fdio_oe != 4'b0000) qbad++;
  end

  function automatic logic [21:0] outv();
    return {host.cmd_ready, host.rsp_valid, host.rsp_data, host.err, host.busy,
            fsclk, fcen, fdio_o, fdio_oe};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic mon();
    logic [8:0] e;
    forever begin
      @(negedge HCLK);
      if (RST && (host.rsp_valid || host.err)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual rsp_valid=%0b err=%0b data=%h expected none",
                   host.rsp_valid, host.err, host.rsp_data);
        end else begin
          e = sb.pop_front();
          chk("scoreboard", {23'd0, host.err, host.err ? 8'h00 : host.rsp_data}, {23'd0, e});
        end
      end
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] d, input logic q, output int bc);
    int n;
    n = 0;
    while (!host.cmd_ready && n < 1000) begin @(posedge HCLK); #1; n++; end
    if (!host.cmd_ready) chk("ready_timeout", 0, 1);
    host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_data = d; quad_req = q;
    @(posedge HCLK); #1;
    host.cmd_valid = 1'b0;
    bc = 0;
    while (host.busy && bc < 5000) begin bc++; @(posedge HCLK); #1; end
    if (host.busy) chk("busy_timeout", 1, 0);
  endtask

  initial begin
    int b, s0, n;
    host.cmd_valid = 1'b0; host.cmd_op = 2'b00; host.cmd_data = 8'h00; quad_req = 1'b0;
    #2 RST = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 chk("reset_init", outv(), RST_V);
    @(negedge HCLK) RST = 1'b1;
    fork mon(); join_none
    @(posedge HCLK); #1;

    // WRITE with fcen high: error pulse, nothing on the wire
    s0 = n_sck;
    sb.push_back({1'b1, 8'h00});
    cmd(OP_WRITE, 8'h3C, 1'b0, b);
    chk("err_busy_cycles", b, 0);
    chk("err_no_sck", n_sck - s0, 0);
    chk("err_ready", host.cmd_ready, 1);
    cmd(OP_STOP, 8'h00, 1'b0, b);
    chk("stop_noop", b, 0);

    // START timing and no-op restart
    cmd(OP_START, 8'h00, 1'b0, b);
    chk("start_cycles", b, 4);
    chk("start_fcen", fcen, 0);
    cmd(OP_START, 8'h00, 1'b0, b);
    chk("start_noop", b, 0);

    // WRITE 0xA5: bits at rising edges, 64 HCLK, 8 pulses
    s0 = n_sck;
    cmd(OP_WRITE, 8'hA5, 1'b0, b);
    chk("wr_cycles", b, 64);
    chk("wr_pulses", n_sck - s0, 8);
    chk("wr_bits", tx_cap, 8'hA5);
    chk("wr_sck_idle", fsclk, 0);
    cmd(OP_STOP, 8'h00, 1'b0, b);
    chk("stop_cycles", b, 8);
    chk("stop_fcen", fcen, 1);

    // JEDEC ID read
    cmd(OP_START, 8'h00, 1'b0, b);
    fcen_hi = 0; fwatch = 1;
    cmd(OP_WRITE, 8'h9F, 1'b0, b);
    sb.push_back({1'b0, 8'hBF}); sb.push_back({1'b0, 8'h26}); sb.push_back({1'b0, 8'h58});
    for (int i = 0; i < 3; i++) begin
      cmd(OP_READ, 8'h00, 1'b0, b);
      chk("rd_cycles", b, 64);
    end
    fwatch = 0;
    chk("rd_fcen_low", fcen_hi, 0);
    cmd(OP_STOP, 8'h00, 1'b0, b);

    // Reset mid-READ after the 3rd rising edge
    cmd(OP_START, 8'h00, 1'b0, b);
    cmd(OP_WRITE, 8'h9F, 1'b0, b);
    s0 = n_sck;
    host.cmd_valid = 1'b1; host.cmd_op = OP_READ;
    @(posedge HCLK); #1;
    host.cmd_valid = 1'b0;
    n = 0;
    while ((n_sck - s0) < 3 && n < 500) begin @(posedge HCLK); #1; n++; end
    chk("rst_reach_edge3", n_sck - s0, 3);
    #3 RST = 1'b0;
    #1 chk("reset_mid_read", outv(), RST_V);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK) RST = 1'b1;
    @(posedge HCLK); #1;
    cmd(OP_START, 8'h00, 1'b0, b);
    cmd(OP_WRITE, 8'h9F, 1'b0, b);
    sb.push_back({1'b0, 8'hBF});
    cmd(OP_READ, 8'h00, 1'b0, b);
    cmd(OP_STOP, 8'h00, 1'b0, b);
    chk("post_rst_fcen", fcen, 1);

`ifdef FLASH_SEQ_QUAD_EN
    // Quad fast read at 0x000010
    cmd(OP_START, 8'h00, 1'b0, b);
    cmd(OP_WRITE, 8'h6B, 1'b0, b);
    cmd(OP_WRITE, 8'h00, 1'b0, b);
    cmd(OP_WRITE, 8'h00, 1'b0, b);
    cmd(OP_WRITE, 8'h10, 1'b0, b);
    cmd(OP_WRITE, 8'h00, 1'b0, b);
    sb.push_back({1'b0, 8'h4A}); sb.push_back({1'b0, 8'h4B});
    s0 = n_sck; qbad = 0; qwatch = 1;
    cmd(OP_READ, 8'h00, 1'b1, b);
    qwatch = 0;
    chk("quad_cycles", b, 16);
    chk("quad_pulses", n_sck - s0, 2);
    chk("quad_oe_off", qbad, 0);
    chk("quad_oe_restore", fdio_oe, 4'b1101);
    cmd(OP_READ, 8'h00, 1'b1, b);
    cmd(OP_STOP, 8'h00, 1'b0, b);
`endif

    repeat (5) @(posedge HCLK);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
